// File: rtl/toaplan2_prog_reader.sv
// Upload-side reader for the Toaplan2 ROM image: maps IOCTL byte addresses onto the
// SDRAM bank/word layout used at download time and returns one byte per read.
module toaplan2_prog_reader #(
  parameter logic [24:0] ROM01_PRG_LEN   = 25'h80000,
  parameter logic [24:0] GP9001_TILE_LEN = 25'h200000,
  parameter logic [24:0] PCM_DATA_LEN    = 25'h80000,
  parameter logic [25:0] PCM_OFFS        = 26'h120000,
  parameter int          TIMEOUT         = 255
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        UPLOADING,
  input  logic        IOCTL_RD,
  input  logic [25:0] IOCTL_ADDR,
  input  logic [7:0]  GAME,
  output logic [7:0]  IOCTL_DIN,
  output logic        IOCTL_WAIT,
  output logic        RD_ERR,
  output logic [21:0] PROG_ADDR,
  output logic [1:0]  PROG_BA,
  output logic        PROG_RD,
  input  logic [15:0] PROG_DOUT,
  input  logic        PROG_RDY
);

  // state  | meaning
  // S_IDLE | accept IOCTL reads; answer GAME / out-of-range / cache hits directly
  // S_REQ  | raise PROG_RD, load the ready timer
  // S_WAIT | hold PROG_RD until PROG_RDY or timer expiry
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [25:0] ROM_BASE  = 26'd1;
  localparam logic [25:0] TILE_BASE = ROM_BASE + {1'b0, ROM01_PRG_LEN};
  localparam logic [25:0] PCM_BASE  = TILE_BASE + {1'b0, GP9001_TILE_LEN};
  localparam logic [25:0] ROM_END   = PCM_BASE + {1'b0, PCM_DATA_LEN};
  localparam logic [7:0]  TMR_LOAD  = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  tmr;
  logic        lane_q;

  logic        cache_vld;
  logic [1:0]  cache_ba;
  logic [21:0] cache_word;
  logic [15:0] cache_data;

  logic [25:0] dec_off;
  logic [1:0]  dec_ba;
  logic [21:0] dec_word;
  logic        dec_lane;
  logic        cache_hit;
  logic [7:0]  cache_byte;

  // Region bases are odd, so the lane follows the offset inside the region, not raw a[0].
  always_comb begin
    dec_off = 26'd0;
    dec_ba  = 2'd0;
    if (IOCTL_ADDR < TILE_BASE) begin
      dec_off = IOCTL_ADDR - ROM_BASE;
      dec_ba  = 2'd0;
    end else if (IOCTL_ADDR < PCM_BASE) begin
      dec_off = IOCTL_ADDR - TILE_BASE;
      dec_ba  = 2'd1;
    end else begin
      dec_off = IOCTL_ADDR - PCM_BASE + PCM_OFFS;
      dec_ba  = 2'd0;
    end
  end

  assign dec_word   = 22'(dec_off >> 1);
  assign dec_lane   = dec_off[0];
  assign cache_hit  = cache_vld && (cache_ba == dec_ba) && (cache_word == dec_word);
  assign cache_byte = dec_lane ? cache_data[15:8] : cache_data[7:0];

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      tmr        <= 8'd0;
      lane_q     <= 1'b0;
      IOCTL_DIN  <= 8'd0;
      IOCTL_WAIT <= 1'b0;
      RD_ERR     <= 1'b0;
      PROG_ADDR  <= 22'd0;
      PROG_BA    <= 2'd0;
      PROG_RD    <= 1'b0;
      cache_vld  <= 1'b0;
      cache_ba   <= 2'd0;
      cache_word <= 22'd0;
      cache_data <= 16'd0;
    end else if (!UPLOADING) begin
      // Leaving the upload session aborts any fetch and drops all cached state.
      state      <= S_IDLE;
      IOCTL_WAIT <= 1'b0;
      PROG_RD    <= 1'b0;
      RD_ERR     <= 1'b0;
      cache_vld  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (IOCTL_RD) begin
            if (IOCTL_ADDR == 26'd0) begin
              IOCTL_DIN <= GAME;
            end else if (IOCTL_ADDR >= ROM_END) begin
              IOCTL_DIN <= 8'hFF;
            end else if (cache_hit) begin
              IOCTL_DIN <= cache_byte;
            end else begin
              PROG_ADDR  <= dec_word;
              PROG_BA    <= dec_ba;
              lane_q     <= dec_lane;
              IOCTL_WAIT <= 1'b1;
              state      <= S_REQ;
            end
          end
        end
        S_REQ: begin
          PROG_RD <= 1'b1;
          tmr     <= TMR_LOAD;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (PROG_RDY) begin
            IOCTL_DIN  <= lane_q ? PROG_DOUT[15:8] : PROG_DOUT[7:0];
            cache_vld  <= 1'b1;
            cache_ba   <= PROG_BA;
            cache_word <= PROG_ADDR;
            cache_data <= PROG_DOUT;
            PROG_RD    <= 1'b0;
            IOCTL_WAIT <= 1'b0;
            state      <= S_IDLE;
          end else if (tmr == 8'd0) begin
            IOCTL_DIN  <= 8'hFF;
            RD_ERR     <= 1'b1;
            PROG_RD    <= 1'b0;
            IOCTL_WAIT <= 1'b0;
            state      <= S_IDLE;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        default: begin
          PROG_RD    <= 1'b0;
          IOCTL_WAIT <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toaplan2_prog_reader.sv
// Scoreboard bench for toaplan2_prog_reader: stimulus queues expected IOCTL_DIN bytes,
// a monitor pops and compares them as each read completes.
module tb_toaplan2_prog_reader;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        UPLOADING = 1'b0;
  logic        IOCTL_RD = 1'b0;
  logic [25:0] IOCTL_ADDR = '0;
  logic [7:0]  GAME = 8'h01;
  logic [7:0]  IOCTL_DIN;
  logic        IOCTL_WAIT;
  logic        RD_ERR;
  logic [21:0] PROG_ADDR;
  logic [1:0]  PROG_BA;
  logic        PROG_RD;
  logic [15:0] PROG_DOUT = '0;
  logic        PROG_RDY = 1'b0;

  int total = 0;
  int bad = 0;
  int prog_rd_rises = 0;
  logic prog_rd_d = 1'b0;
  // bit 8 = compare this entry; entries with bit 8 clear are aborted reads
  logic [8:0] exp_q[$];

  toaplan2_prog_reader dut (
    .CLK(CLK), .RESET_N(RESET_N), .UPLOADING(UPLOADING), .IOCTL_RD(IOCTL_RD),
    .IOCTL_ADDR(IOCTL_ADDR), .GAME(GAME), .IOCTL_DIN(IOCTL_DIN), .IOCTL_WAIT(IOCTL_WAIT),
    .RD_ERR(RD_ERR), .PROG_ADDR(PROG_ADDR), .PROG_BA(PROG_BA), .PROG_RD(PROG_RD),
    .PROG_DOUT(PROG_DOUT), .PROG_RDY(PROG_RDY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (PROG_RD && !prog_rd_d) prog_rd_rises++;
    prog_rd_d = PROG_RD;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic [8:0] e;
    int n;
    forever begin
      @(posedge CLK);
      if (IOCTL_RD && UPLOADING && RESET_N) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard: read seen with no expected entry");
        end else begin
          e = exp_q.pop_front();
          @(negedge CLK);
          n = 0;
          while (IOCTL_WAIT && n < 400) begin
            @(negedge CLK);
            n++;
          end
          if (e[8]) begin
            if (n >= 400) begin
              total++;
              bad++;
              $display("FAIL ioctl_din_timeout: wait still high, expected byte %0h", e[7:0]);
            end else begin
              check("ioctl_din", {24'd0, IOCTL_DIN}, {24'd0, e[7:0]});
            end
          end
        end
      end
    end
  end

  task automatic issue(input logic [25:0] a, input logic [8:0] e);
    exp_q.push_back(e);
    @(negedge CLK);
    IOCTL_ADDR = a;
    IOCTL_RD = 1'b1;
    @(negedge CLK);
    IOCTL_RD = 1'b0;
  endtask

  task automatic imm(input logic [25:0] a, input logic [7:0] d);
    int r0;
    r0 = prog_rd_rises;
    issue(a, {1'b1, d});
    check("imm_wait_low", {31'd0, IOCTL_WAIT}, 32'd0);
    repeat (2) @(negedge CLK);
    check("imm_no_prog_rd", prog_rd_rises, r0);
  endtask

  task automatic start_miss(input logic [25:0] a, input logic [8:0] e);
    issue(a, e);
    check("miss_wait_high", {31'd0, IOCTL_WAIT}, 32'd1);
    check("miss_prog_rd_latency", {31'd0, PROG_RD}, 32'd0);
    @(negedge CLK);
    check("miss_prog_rd", {31'd0, PROG_RD}, 32'd1);
  endtask

  task automatic do_miss(input logic [25:0] a, input logic [1:0] ba, input logic [21:0] word,
                         input logic [15:0] data, input int dly, input logic [7:0] d);
    start_miss(a, {1'b1, d});
    check("prog_ba", {30'd0, PROG_BA}, {30'd0, ba});
    check("prog_addr", {10'd0, PROG_ADDR}, {10'd0, word});
    repeat (dly) @(negedge CLK);
    check("prog_addr_stable", {10'd0, PROG_ADDR}, {10'd0, word});
    PROG_DOUT = data;
    PROG_RDY = 1'b1;
    @(negedge CLK);
    PROG_RDY = 1'b0;
    check("rdy_prog_rd_fall", {31'd0, PROG_RD}, 32'd0);
    check("rdy_wait_fall", {31'd0, IOCTL_WAIT}, 32'd0);
    @(negedge CLK);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_din"}, {24'd0, IOCTL_DIN}, 32'd0);
    check({tag, "_wait"}, {31'd0, IOCTL_WAIT}, 32'd0);
    check({tag, "_rd_err"}, {31'd0, RD_ERR}, 32'd0);
    check({tag, "_prog_rd"}, {31'd0, PROG_RD}, 32'd0);
    check({tag, "_prog_addr"}, {10'd0, PROG_ADDR}, 32'd0);
    check({tag, "_prog_ba"}, {30'd0, PROG_BA}, 32'd0);
  endtask

  initial begin : stim
    int n;
    repeat (3) @(negedge CLK);
    check_reset_values("reset");
    RESET_N = 1'b1;
    UPLOADING = 1'b1;
    @(negedge CLK);

    imm(26'h0000000, 8'h01);
    do_miss(26'h0000001, 2'd0, 22'h000000, 16'hBEEF, 5, 8'hEF);
    imm(26'h0000002, 8'hBE);
    do_miss(26'h0080001, 2'd1, 22'h000000, 16'h1234, 2, 8'h34);
    imm(26'h0080002, 8'h12);
    do_miss(26'h0280001, 2'd0, 22'h090000, 16'h5678, 1, 8'h78);
    imm(26'h0280002, 8'h56);
    do_miss(26'h0080002, 2'd1, 22'h000000, 16'h1234, 0, 8'h12);
    do_miss(26'h0080000, 2'd0, 22'h03FFFF, 16'h9ABC, 1, 8'h9A);
    do_miss(26'h0300000, 2'd0, 22'h0CFFFF, 16'hCAFE, 3, 8'hCA);
    imm(26'h0300001, 8'hFF);
    imm(26'h3FFFFFF, 8'hFF);

    // reads outside an upload session are ignored
    UPLOADING = 1'b0;
    GAME = 8'h5A;
    @(negedge CLK);
    IOCTL_ADDR = 26'h0;
    IOCTL_RD = 1'b1;
    @(negedge CLK);
    IOCTL_RD = 1'b0;
    repeat (2) @(negedge CLK);
    check("no_upload_ignored", {24'd0, IOCTL_DIN}, 32'h0000_00FF);
    UPLOADING = 1'b1;
    @(negedge CLK);

    // PROG_RDY never arrives
    start_miss(26'h0000011, {1'b1, 8'hFF});
    n = 0;
    while (PROG_RD && n < 400) begin
      n++;
      @(negedge CLK);
    end
    check("timeout_cycles", n, 255);
    check("timeout_rd_err", {31'd0, RD_ERR}, 32'd1);
    check("timeout_wait_low", {31'd0, IOCTL_WAIT}, 32'd0);
    @(negedge CLK);
    do_miss(26'h0000011, 2'd0, 22'h000008, 16'hA5C3, 3, 8'hC3);
    check("rd_err_sticky", {31'd0, RD_ERR}, 32'd1);

    // abort by dropping UPLOADING mid-fetch
    start_miss(26'h0000101, 9'h000);
    repeat (2) @(negedge CLK);
    UPLOADING = 1'b0;
    @(negedge CLK);
    check("abort_wait", {31'd0, IOCTL_WAIT}, 32'd0);
    check("abort_prog_rd", {31'd0, PROG_RD}, 32'd0);
    check("abort_rd_err_clr", {31'd0, RD_ERR}, 32'd0);
    check("abort_din_held", {24'd0, IOCTL_DIN}, 32'h0000_00C3);
    UPLOADING = 1'b1;
    @(negedge CLK);
    do_miss(26'h0000012, 2'd0, 22'h000008, 16'h7788, 2, 8'h77);

    // reset mid-fetch, then a stray PROG_RDY
    start_miss(26'h0000201, 9'h000);
    @(negedge CLK);
    RESET_N = 1'b0;
    @(negedge CLK);
    check_reset_values("midreset");
    RESET_N = 1'b1;
    PROG_DOUT = 16'h1111;
    PROG_RDY = 1'b1;
    @(negedge CLK);
    PROG_RDY = 1'b0;
    @(negedge CLK);
    check("stray_rdy_din", {24'd0, IOCTL_DIN}, 32'd0);
    check("stray_rdy_wait", {31'd0, IOCTL_WAIT}, 32'd0);
    check("stray_rdy_prog_rd", {31'd0, PROG_RD}, 32'd0);
    do_miss(26'h0000012, 2'd0, 22'h000008, 16'h7788, 1, 8'h77);

    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
